bitwise_serial_alu: RTL



---
 rtl/bitwise_pkg.sv | 42 ++++
 rtl/bitwise_bit_cell.sv | 19 +
 rtl/bitwise_serial_alu.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bitwise_pkg.sv
// rtl/bitwise_pkg.sv - shared opcode/state types and the 1-bit logic function
// Purpose: opcode and FSM state encodings plus bit_op(), the single-bit
//   reference of the eight logic operations. The parallel unit's bench model
//   uses bit_op() too, so both units agree on the opcode encoding.
// Ports: none (package).
package bitwise_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_XNOR = 3'd3,
      OP_NOT  = 3'd4,
      OP_NAND = 3'd5,
      OP_NOR  = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic bit_op(op_e op, logic a, logic b);
      logic y;
      y = 1'b0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NOT:  y = ~a;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_PASS: y = a;
         default: y = 1'b0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/bitwise_bit_cell.sv
// rtl/bitwise_bit_cell.sv - combinational 1-bit logic-op evaluator
// Purpose: evaluates the selected opcode on one bit pair.
// Ports:
//   op  in  op_e  opcode
//   a   in  1     operand A bit
//   b   in  1     operand B bit
//   y   out 1     result bit
module bitwise_bit_cell
   import bitwise_pkg::*;
(
   input  op_e  op,
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = bit_op(op, a, b);

endmodule

// File: rtl/bitwise_serial_alu.sv
// rtl/bitwise_serial_alu.sv - bit-serial 8-op logic unit with valid/ready handshakes
// Purpose: accepts one operand pair + opcode, evaluates one bit per clock
//   LSB first over WIDTH cycles, then presents the whole word until the sink
//   takes it. Optional macro BITWISE_PARITY_EN adds a registered even-parity
//   output aligned with y_out.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   a_in       in   WIDTH  operand A, sampled on accept
//   b_in       in   WIDTH  operand B, sampled on accept
//   op_in      in   3      opcode, sampled on accept
//   valid_in   in   1      operand request valid
//   ready_out  out  1      high while idle
//   y_out      out  WIDTH  result word, stable while valid_out
//   valid_out  out  1      result valid
//   ready_in   in   1      sink accepts result
//   parity_out out  1      ^y_out (BITWISE_PARITY_EN only)
module bitwise_serial_alu
   import bitwise_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [2:0]       op_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic [WIDTH-1:0] y_out,
   output logic             valid_out,
   input  logic             ready_in
`ifdef BITWISE_PARITY_EN
   ,
   output logic             parity_out
`endif
);

   localparam logic [1:0] ST_IDLE = S_IDLE;
   localparam logic [1:0] ST_BUSY = S_BUSY;
   localparam logic [1:0] ST_DONE = S_DONE;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] y_q, y_d;
   op_e              op_q, op_d;
   logic             bit_y;
   logic             finish;

   bitwise_bit_cell u_cell (
      .op (op_q),
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .y  (bit_y)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      y_d     = y_q;
      op_d    = op_q;
      finish  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (valid_in) begin
               a_sh_d  = a_in;
               b_sh_d  = b_in;
               op_d    = op_e'(op_in);
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            // LSB-first results enter at the MSB so the word is aligned after WIDTH shifts
            res_d  = {bit_y, res_q[WIDTH-1:1]};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               finish  = 1'b1;
               y_d     = res_d;
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // a request arriving on the drain edge waits for the idle cycle
            if (ready_in) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         y_q     <= '0;
         op_q    <= OP_AND;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         y_q     <= y_d;
         op_q    <= op_d;
      end
   end

`ifdef BITWISE_PARITY_EN
   logic parity_q, parity_d;

   always_comb begin
      parity_d = parity_q;
      if (finish) begin
         parity_d = ^y_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign parity_out = parity_q;
`else
   logic unused_finish;
   assign unused_finish = finish;
`endif

   assign ready_out = (state_q == ST_IDLE);
   assign valid_out = (state_q == ST_DONE);
   assign y_out     = y_q;

endmodule
